// File: rtl/len_counter_pkg.sv
// Shared sound-block constants for the per-voice note-length counters.
package len_counter_pkg;

  // Default length-counter width used by every voice channel.
  localparam int unsigned LEN_W = 32'd8;

  // Largest unsigned value representable in 'width' bits, clamped to 32 bits.
  function automatic int unsigned len_terminal(input int unsigned width);
    if (width >= 32'd32) begin
      return 32'hFFFF_FFFF;
    end else begin
      return (32'd1 << width) - 32'd1;
    end
  endfunction

  // Default note-length terminal value: the full range of the default width.
  localparam int unsigned LEN_MAX_DEFAULT = len_terminal(LEN_W);

endpackage

// File: rtl/len_counter.sv
// Note-length counter: counts enabled clock cycles since the last reset or
// clear. It flags the terminal count and either rolls over or saturates there.
module len_counter
  import len_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = LEN_W,
  parameter int unsigned MAX_COUNT = len_terminal(WIDTH),
  parameter bit          WRAP      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ZERO_V = WIDTH'(32'd0);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(32'd1);

  logic [WIDTH-1:0] count_r;
  logic             wrapped_r;
  logic [WIDTH-1:0] next_count_s;
  logic             next_wrapped_s;
  logic             tc_s;

  // Terminal decode plus next-state selection: clear beats enable, and enable beats hold.
  always_comb begin
    next_count_s   = count_r;
    next_wrapped_s = 1'b0;
    tc_s           = (count_r == MAX_V);
    if (clear) begin
      // A restart is never reported as a wrap, even from the terminal value.
      next_count_s   = ZERO_V;
      next_wrapped_s = 1'b0;
    end else if (en) begin
      if (!tc_s) begin
        next_count_s   = count_r + ONE_V;
        next_wrapped_s = 1'b0;
      end else if (WRAP) begin
        next_count_s   = ZERO_V;
        next_wrapped_s = 1'b1;
      end else begin
        next_count_s   = MAX_V;
        next_wrapped_s = 1'b0;
      end
    end else begin
      next_count_s   = count_r;
      next_wrapped_s = 1'b0;
    end
  end

  // State registers: reset clears immediately and cancels any pending wrap pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r   <= ZERO_V;
      wrapped_r <= 1'b0;
    end else begin
      count_r   <= next_count_s;
      wrapped_r <= next_wrapped_s;
    end
  end

  assign count   = count_r;
  assign tc      = tc_s;
  assign wrapped = wrapped_r;

endmodule

// File: tb/tb_len_counter.sv
// Self-checking bench for len_counter. It drives a saturating instance, four
// default voice channels and a small 4-bit wrapping instance, and checks them
// against an edge-count reference model.
module tb_len_counter;
  import len_counter_pkg::*;

  localparam int N = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst [N];
  logic             en  [N];
  logic             clr [N];
  logic [LEN_W-1:0] cnt [5];
  logic [3:0]       cnt_small;
  logic             tc  [N];
  logic             wrp [N];

  int tests    = 0;
  int failures = 0;

  // Reference model: n = enabled edges since the last reset/clear.
  int n     [N];
  int mx    [N];
  bit wmode [N];
  bit exp_w [N];

  len_counter #(.WIDTH(8), .MAX_COUNT(10), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(rst[0]), .en(en[0]), .clear(clr[0]),
    .count(cnt[0]), .tc(tc[0]), .wrapped(wrp[0]));

  for (genvar g = 1; g < 5; g++) begin : g_ch
    len_counter u_ch (
      .clk(clk), .reset(rst[g]), .en(en[g]), .clear(clr[g]),
      .count(cnt[g]), .tc(tc[g]), .wrapped(wrp[g]));
  end

  len_counter #(.WIDTH(4), .MAX_COUNT(9), .WRAP(1'b1)) u_small (
    .clk(clk), .reset(rst[5]), .en(en[5]), .clear(clr[5]),
    .count(cnt_small), .tc(tc[5]), .wrapped(wrp[5]));

  function automatic int exp_count(input int i);
    if (wmode[i]) return n[i] % (mx[i] + 1);
    else          return (n[i] < mx[i]) ? n[i] : mx[i];
  endfunction

  function automatic logic [31:0] act_count(input int i);
    if (i == 5) return 32'(cnt_small);
    else        return 32'(cnt[i]);
  endfunction

  task automatic model_edge(input int i);
    if (rst[i] || clr[i]) begin
      n[i] = 0; exp_w[i] = 1'b0;
    end else if (en[i]) begin
      n[i] = n[i] + 1;
      exp_w[i] = wmode[i] && ((n[i] % (mx[i] + 1)) == 0);
    end else begin
      exp_w[i] = 1'b0;
    end
  endtask

  task automatic model_async_reset(input int i);
    n[i] = 0; exp_w[i] = 1'b0;
  endtask

  task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s[%0d]: got %0d expected %0d", tag, i, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      chk({tag, ".count"}, i, act_count(i), 32'(exp_count(i)));
      chk({tag, ".tc"}, i, 32'(tc[i]), 32'(exp_count(i) == mx[i]));
      chk({tag, ".wrapped"}, i, 32'(wrp[i]), 32'(exp_w[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < N; i++) model_edge(i);
    #1;
  endtask

  task automatic step(input string tag);
    tick();
    check_all(tag);
  endtask

  // Advance until channel i's model reaches target; the limit bounds the wait.
  task automatic run_until(input int i, input int target, input int limit);
    for (int k = 0; k < limit && exp_count(i) != target; k++) step("run");
    chk("reach", i, act_count(i), 32'(target));
  endtask

  initial begin
    mx    = '{10, 255, 255, 255, 255, 9};
    wmode = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; clr[i] = 1'b0;
      n[i] = 0; exp_w[i] = 1'b0;
    end

    // Reset takes effect before any clock edge, and holds while asserted.
    #1;
    check_all("reset_async");
    step("reset_held");
    step("reset_held");

    // Release and count up; the first increment lands on the first enabled edge.
    for (int i = 0; i < N; i++) begin rst[i] = 1'b0; en[i] = 1'b1; end
    for (int k = 1; k <= 5; k++) begin
      step("count_up");
      chk("count_up_ch1", 1, 32'(cnt[1]), 32'(k));
      chk("count_up_tc", 1, 32'(tc[1]), 32'd0);
    end

    // Saturating instance stops at 10 after 15 enabled edges.
    for (int k = 0; k < 10; k++) step("sat_run");
    chk("sat_hold", 0, 32'(cnt[0]), 32'd10);
    chk("sat_tc", 0, 32'(tc[0]), 32'd1);

    // Independent resets: only channel 2 is reset at count 20.
    run_until(1, 20, 600);
    rst[2] = 1'b1;
    #1;
    model_async_reset(2);
    check_all("ch2_async_rst");
    chk("ch2_zero", 2, 32'(cnt[2]), 32'd0);
    chk("ch3_kept", 3, 32'(cnt[3]), 32'd20);
    step("ch2_held");
    step("ch2_held");
    chk("ch1_runs", 1, 32'(cnt[1]), 32'd22);
    rst[2] = 1'b0;
    step("ch2_release");
    chk("ch2_one", 2, 32'(cnt[2]), 32'd1);

    // Asynchronous reset at count 37 on channel 4.
    run_until(4, 37, 600);
    rst[4] = 1'b1;
    #1;
    model_async_reset(4);
    chk("ch4_async_zero", 4, 32'(cnt[4]), 32'd0);
    step("ch4_held");
    chk("ch4_held_zero", 4, 32'(cnt[4]), 32'd0);
    rst[4] = 1'b0;
    step("ch4_release");
    chk("ch4_one", 4, 32'(cnt[4]), 32'd1);

    // Roll over at 255 with a single-cycle wrapped pulse.
    run_until(1, 255, 600);
    chk("wrap_tc", 1, 32'(tc[1]), 32'd1);
    step("wrap_edge");
    chk("wrap_zero", 1, 32'(cnt[1]), 32'd0);
    chk("wrap_pulse", 1, 32'(wrp[1]), 32'd1);
    step("wrap_after");
    chk("wrap_one", 1, 32'(cnt[1]), 32'd1);
    chk("wrap_drop", 1, 32'(wrp[1]), 32'd0);

    // Hold with en low, then clear wins over en.
    run_until(1, 6, 600);
    en[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step("en_low");
      chk("hold6", 1, 32'(cnt[1]), 32'd6);
    end
    en[1] = 1'b1; clr[1] = 1'b1;
    step("clr_en");
    chk("clr_zero", 1, 32'(cnt[1]), 32'd0);
    chk("clr_nowrap", 1, 32'(wrp[1]), 32'd0);
    clr[1] = 1'b0;
    step("after_clr");
    chk("after_clr_one", 1, 32'(cnt[1]), 32'd1);

    // Clear at the terminal value is not a wrap (saturating and wrapping).
    clr[0] = 1'b1;
    run_until(5, 9, 20);
    clr[5] = 1'b1;
    step("clr_at_max");
    chk("sat_clr_zero", 0, 32'(cnt[0]), 32'd0);
    chk("small_clr_zero", 5, 32'(cnt_small), 32'd0);
    chk("small_clr_nowrap", 5, 32'(wrp[5]), 32'd0);
    clr[0] = 1'b0; clr[5] = 1'b0;

    // Reset cancels an in-flight wrapped pulse.
    run_until(5, 9, 20);
    step("small_wrap");
    chk("small_wrap_pulse", 5, 32'(wrp[5]), 32'd1);
    rst[5] = 1'b1;
    #1;
    model_async_reset(5);
    chk("wrap_cancel", 5, 32'(wrp[5]), 32'd0);
    rst[5] = 1'b0;
    step("small_release");

    // Randomized traffic on every instance.
    for (int it = 0; it < 400; it++) begin
      for (int i = 0; i < N; i++) begin
        en[i]  = ($urandom_range(0, 3) != 0);
        clr[i] = ($urandom_range(0, 15) == 0);
        rst[i] = ($urandom_range(0, 31) == 0);
        if (rst[i]) model_async_reset(i);
      end
      if ($urandom_range(0, 7) == 0) begin
        #1;
        check_all("rand_async");
      end
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/len_counter.md
Name: len_counter

Overview:
- Free-running note-length counter used by the tone-control logic, one instance per voice channel (four in the sound block).
- Counts clock cycles since the last reset so the controller can time note durations.
- The controller restarts the count by asserting reset.
- Also flags when a programmed terminal count is reached.

Parameters:
- WIDTH, 8, bit width of the count output.
- MAX_COUNT, 2**WIDTH-1, terminal value. Must be at least 1 and at most 2**WIDTH-1.
- WRAP, 1, behaviour at MAX_COUNT: 1 = roll over to 0, 0 = saturate (hold at MAX_COUNT).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- en  input  1  count enable; the count advances only when high.
- clear  input  1  synchronous restart; count goes to 0 on the next edge.
- count  output  WIDTH  current cycle count since the last reset or clear.
- tc  output  1  high while count == MAX_COUNT (combinational decode of count).
- wrapped  output  1  single-cycle pulse on the edge where count rolls from MAX_COUNT to 0 (WRAP=1 only).

Behaviour:
- Reset: when reset is asserted, count=0, wrapped=0, and therefore tc=0, without waiting for a clock edge.
- Reset remains dominant while held. The first increment occurs on the first rising edge after deassertion, provided en=1.
- Priority on each rising edge: reset > clear > en > hold.
- clear=1: count<=0 and wrapped<=0, regardless of en.
- en=1, count<MAX_COUNT: count<=count+1 and wrapped<=0.
- en=1, count==MAX_COUNT, WRAP=1: count<=0 and wrapped<=1 for exactly one cycle.
- en=1, count==MAX_COUNT, WRAP=0: count holds at MAX_COUNT and wrapped stays 0.
- en=0: count holds and wrapped<=0.
- Latency: count reflects an increment one cycle after the enabled edge. tc follows count with zero added latency.
- Arithmetic is unsigned, WIDTH bits. There is never an overflow beyond MAX_COUNT; values above MAX_COUNT are unreachable.
- Reset asserted mid-count: count goes to 0 asynchronously and any in-flight wrapped pulse is cancelled.
- clear and en both high on the same edge: clear wins (count=0, no increment).
- clear while count==MAX_COUNT: count goes to 0 and wrapped stays 0, because a clear is not a wrap.
- No X propagation: every register has a defined reset value.

Decomposition:
- Shared sound package holds:
  - LEN_W = 8, the default length-counter width used by all channels.
  - Constant for the default note-length terminal value.
- No sub-module; the block is a single flat module.
- The tc decode and next-count logic live in one combinational process feeding one sequential process.

Test Plan:
- Reset then count: assert reset, release, hold en=1 for 5 edges -> count=0,1,2,3,4,5; tc=0 throughout.
- Async reset mid-count: with count=37, raise reset between edges -> count=0 before the next clk edge. It stays 0 while reset is held and reads 1 one edge after release (en=1).
- Wrap, WIDTH=8, MAX_COUNT=255, WRAP=1: count to 255 -> tc=1 at 255. The next enabled edge gives count=0 and wrapped=1 for one cycle, then wrapped=0 at count=1.
- Saturate, MAX_COUNT=10, WRAP=0: run 15 enabled edges -> count stops at 10, tc stays 1, wrapped never asserts.
- Enable and clear: at count=6 drop en for 3 edges -> count holds at 6. Raise en and clear together -> count=0 and wrapped=0. Next enabled edge -> count=1.
- Four instances under independent resets: reset only instance 2 at count=20 -> instance 2 reads 0 while instances 1, 3 and 4 continue counting uninterrupted.
